// File: rtl/tick_gen_prog.sv
// tick_gen_prog: programmable periodic / one-shot tick generator with a cascaded slow tick.
// Optional slow counter: define TICK_GEN_SLOW_EN to build it, otherwise tick_slow is tied low.
module tick_gen_prog #(
    parameter int          CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 10_000_000,
    parameter int          SLOW_DIV    = 10,
    parameter int          SLOW_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic             mode,
    input  logic             start,
    output logic             tick,
    output logic             tick_slow,
    output logic             busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;
    logic             tick_q;
    logic             active, arm, tc;

    // Divisors of 0 and 1 both mean "tick on every counted cycle".
    assign last_cnt = (div_q <= CNT_W'(1)) ? '0 : div_q - CNT_W'(1);
    assign arm      = start & mode;
    assign active   = en & (~mode | (state_q == RUN));
    // Any strobe pre-empts counting, so a terminal count never coincides with one.
    assign tc       = active & (cnt_q == last_cnt) & ~clr & ~div_load & ~arm;

    always_comb begin
        div_d   = div_load ? div_in : div_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clr | div_load | arm | tc) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A start in the same cycle as clr still arms a fresh run.
        if (arm) begin
            state_d = RUN;
        end else if (clr | ~mode | tc) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= CNT_W'(DEFAULT_DIV);
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tick_q  <= tc;
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == RUN);

`ifdef TICK_GEN_SLOW_EN
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

    logic [SLOW_W-1:0] slow_q, slow_d;
    logic              tick_slow_q;

    always_comb begin
        slow_d = slow_q;
        if (clr) begin
            slow_d = '0;
        end else if (tc) begin
            slow_d = (slow_q == SLOW_LAST) ? '0 : slow_q + SLOW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_q      <= '0;
            tick_slow_q <= 1'b0;
        end else begin
            slow_q      <= slow_d;
            tick_slow_q <= tc & (slow_q == SLOW_LAST);
        end
    end

    assign tick_slow = tick_slow_q;
`else
    logic unused_slow_cfg;
    assign unused_slow_cfg = (SLOW_DIV > SLOW_W);
    assign tick_slow       = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen_prog.sv
// Bench for tick_gen_prog: directed scenarios plus randomized traffic against a period-level model.
module tb_tick_gen_prog;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 5;
    localparam int SLOW_DIV    = 3;
    localparam int SLOW_W      = 2;
`ifdef TICK_GEN_SLOW_EN
    localparam bit SLOW_ON = 1'b1;
`else
    localparam bit SLOW_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0, clr = 1'b0, div_load = 1'b0, mode = 1'b0, start = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             tick, tick_slow, busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: period length, active cycles elapsed in the current period, ticks since last clear.
    int   m_div, m_elapsed, m_ticks;
    bit   m_busy;
    logic e_tick, e_slow;

    tick_gen_prog #(
        .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .SLOW_DIV(SLOW_DIV), .SLOW_W(SLOW_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .div_in(div_in), .div_load(div_load),
        .mode(mode), .start(start), .tick(tick), .tick_slow(tick_slow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_div = DEFAULT_DIV; m_elapsed = 0; m_ticks = 0; m_busy = 0;
        e_tick = 1'b0; e_slow = 1'b0;
    endtask

    // Advance one clock edge; the model consumes the inputs present before the edge.
    task automatic cycle();
        int  period;
        bit  counting, armed, restart, fire;
        period   = (m_div < 2) ? 1 : m_div;
        armed    = start && mode;
        counting = en && (!mode || m_busy);
        restart  = clr || div_load || armed;
        fire     = counting && !restart && (m_elapsed + 1 >= period);
        e_tick   = fire;
        e_slow   = SLOW_ON && fire && ((m_ticks + 1) % SLOW_DIV == 0);
        if (div_load) m_div = int'(div_in);
        if (clr) m_ticks = 0;
        else if (fire) m_ticks = m_ticks + 1;
        if (restart || fire) m_elapsed = 0;
        else if (counting) m_elapsed = m_elapsed + 1;
        if (armed) m_busy = 1;
        else if (clr || !mode || fire) m_busy = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b want 0", tick); end
        tests_run++; if (tick_slow !== 1'b0) begin tests_failed++; $display("FAIL reset_tick_slow: got %b want 0", tick_slow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        en = 1'b1; mode = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_periodic();
        for (int c = 1; c <= 15; c++) begin
            cycle();
            tests_run++; if (tick !== (c % 5 == 0)) begin tests_failed++; $display("FAIL periodic_tick c=%0d: got %b want %b", c, tick, (c % 5 == 0)); end
            tests_run++; if (tick_slow !== (SLOW_ON && c == 15)) begin tests_failed++; $display("FAIL periodic_slow c=%0d: got %b want %b", c, tick_slow, (SLOW_ON && c == 15)); end
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL periodic_busy c=%0d: got %b want 0", c, busy); end
        end
    endtask

    task automatic test_enable_clear();
        int first_tick, n_ticks, first_slow;
        clr = 1'b1; cycle(); clr = 1'b0;
        first_tick = -1; n_ticks = 0;
        for (int c = 1; c <= 11; c++) begin
            en = !(c >= 3 && c <= 5);
            cycle();
            if (tick === 1'b1) begin n_ticks++; if (first_tick < 0) first_tick = c; end
        end
        en = 1'b1;
        tests_run++; if (first_tick !== 8) begin tests_failed++; $display("FAIL enable_gap_tick_at: got %0d want 8", first_tick); end
        tests_run++; if (n_ticks !== 1) begin tests_failed++; $display("FAIL enable_gap_tick_count: got %0d want 1", n_ticks); end
        // Counter sits at 3 here and the slow count at 1.
        clr = 1'b1; cycle(); clr = 1'b0;
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL clear_tick: got %b want 0", tick); end
        first_tick = -1; first_slow = -1;
        for (int d = 1; d <= 16; d++) begin
            cycle();
            if (tick === 1'b1 && first_tick < 0) first_tick = d;
            if (tick_slow === 1'b1 && first_slow < 0) first_slow = d;
        end
        tests_run++; if (first_tick !== 5) begin tests_failed++; $display("FAIL clear_next_tick: got %0d want 5", first_tick); end
        tests_run++; if (first_slow !== (SLOW_ON ? 15 : -1)) begin tests_failed++; $display("FAIL clear_slow_restart: got %0d want %0d", first_slow, (SLOW_ON ? 15 : -1)); end
    endtask

    task automatic test_div_load();
        logic [CNT_W-1:0] divs [3];
        divs[0] = 8'd0; divs[1] = 8'd1; divs[2] = 8'd2;
        div_in = 8'd2; div_load = 1'b1; cycle(); div_load = 1'b0;
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL load_tick_cleared: got %b want 0", tick); end
        for (int d = 1; d <= 8; d++) begin
            cycle();
            tests_run++; if (tick !== (d % 2 == 0)) begin tests_failed++; $display("FAIL div2_tick d=%0d: got %b want %b", d, tick, (d % 2 == 0)); end
            tests_run++; if (tick_slow !== e_slow) begin tests_failed++; $display("FAIL div2_slow d=%0d: got %b want %b", d, tick_slow, e_slow); end
        end
        for (int k = 0; k < 2; k++) begin
            div_in = divs[k]; div_load = 1'b1; cycle(); div_load = 1'b0;
            for (int d = 1; d <= 6; d++) begin
                cycle();
                tests_run++; if (tick !== 1'b1) begin tests_failed++; $display("FAIL div%0d_tick d=%0d: got %b want 1", k, d, tick); end
                tests_run++; if (tick_slow !== e_slow) begin tests_failed++; $display("FAIL div%0d_slow d=%0d: got %b want %b", k, d, tick_slow, e_slow); end
            end
        end
        div_in = 8'd5; div_load = 1'b1; cycle(); div_load = 1'b0;
    endtask

    task automatic test_one_shot();
        int busy_cnt, tick_cnt, tick_at;
        mode = 1'b1; start = 1'b1; cycle(); start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL oneshot_armed: got %b want 1", busy); end
        busy_cnt = 1; tick_cnt = 0; tick_at = -1;
        for (int d = 1; d <= 12; d++) begin
            cycle();
            if (busy === 1'b1) busy_cnt++;
            if (tick === 1'b1) begin tick_cnt++; tick_at = d; end
        end
        tests_run++; if (busy_cnt !== 5) begin tests_failed++; $display("FAIL oneshot_busy_len: got %0d want 5", busy_cnt); end
        tests_run++; if (tick_at !== 5) begin tests_failed++; $display("FAIL oneshot_tick_at: got %0d want 5", tick_at); end
        tests_run++; if (tick_cnt !== 1) begin tests_failed++; $display("FAIL oneshot_tick_count: got %0d want 1", tick_cnt); end
        start = 1'b1; cycle(); start = 1'b0;
        tick_cnt = 0; tick_at = -1;
        for (int d = 1; d <= 14; d++) begin
            start = (d == 3);
            cycle();
            if (tick === 1'b1) begin tick_cnt++; tick_at = d; end
        end
        start = 1'b0;
        tests_run++; if (tick_at !== 8) begin tests_failed++; $display("FAIL restart_tick_at: got %0d want 8", tick_at); end
        tests_run++; if (tick_cnt !== 1) begin tests_failed++; $display("FAIL restart_tick_count: got %0d want 1", tick_cnt); end
    endtask

    task automatic test_simultaneous();
        int tick_at;
        mode = 1'b1; clr = 1'b1; div_load = 1'b1; div_in = 8'd3; start = 1'b1;
        cycle();
        clr = 1'b0; div_load = 1'b0; start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL strobes_busy: got %b want 1", busy); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL strobes_tick: got %b want 0", tick); end
        tick_at = -1;
        for (int d = 1; d <= 4; d++) begin
            cycle();
            if (tick === 1'b1 && tick_at < 0) tick_at = d;
        end
        tests_run++; if (tick_at !== 3) begin tests_failed++; $display("FAIL strobes_tick_at: got %0d want 3", tick_at); end
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL async_rst_busy: got %b want 0", busy); end
        #3 rst = 1'b0;
        model_reset();
        mode = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            cycle();
            tests_run++; if (tick !== (d == 5)) begin tests_failed++; $display("FAIL post_rst_div d=%0d: got %b want %b", d, tick, (d == 5)); end
        end
        div_in = 8'd1; div_load = 1'b1; cycle(); div_load = 1'b0;
        cycle();
        tests_run++; if (tick !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_tick: got %b want 1", tick); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL async_rst_tick: got %b want 0", tick); end
        #3 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 39) == 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_in   = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            start    = ($urandom_range(0, 11) == 0);
            cycle();
            tests_run++; if (tick !== e_tick) begin tests_failed++; $display("FAIL random_tick i=%0d: got %b want %b", i, tick, e_tick); end
            tests_run++; if (tick_slow !== e_slow) begin tests_failed++; $display("FAIL random_slow i=%0d: got %b want %b", i, tick_slow, e_slow); end
            tests_run++; if (busy !== m_busy) begin tests_failed++; $display("FAIL random_busy i=%0d: got %b want %b", i, busy, m_busy); end
        end
        en = 1'b1; clr = 1'b0; div_load = 1'b0; start = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_enable_clear();
        test_div_load();
        test_one_shot();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
